fft_frame_arbiter: RTL
======================

FFT_FRAME_ARBITER -- requirements
Module: fft_frame_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 24: real/imag component width; beat width is 2*DATA_WIDTH.
REQ-002 Parameter NUM_SRC, default 4: number of FFT output streams merged.
REQ-003 Parameter N_FFT_MIN, default 9: source i frame length is 2^(N_FFT_MIN+i) beats.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 s_data  in  NUM_SRC*2*DATA_WIDTH  source beats; source i occupies slice i.
REQ-007 s_valid  in  NUM_SRC  per-source valid.
REQ-008 s_last  in  NUM_SRC  per-source end-of-frame.
REQ-009 s_ready  out  NUM_SRC  per-source ready.
REQ-010 m_data  out  2*DATA_WIDTH  merged beat.
REQ-011 m_valid  out  1  merged valid.
REQ-012 m_last  out  1  merged end-of-frame.
REQ-013 m_ready  in  1  downstream ready.
REQ-014 m_src  out  max(1,$clog2(NUM_SRC))  index of source owning the current frame.
REQ-015 m_channel  out  1  channel tag of the current frame (0 = left, 1 = right).
REQ-016 len_err  out  NUM_SRC  sticky per-source frame-length error flags.

Function
REQ-017 Two states: IDLE and LOCKED; reset state IDLE.
REQ-018 IDLE: m_valid=0, m_last=0, s_ready=0; if any s_valid set, select granted source g by round-robin and enter LOCKED next cycle.
REQ-019 Round-robin: search starts at ptr, ascending with wrap; ptr resets to 0; on frame completion ptr <= g+1 mod NUM_SRC.
REQ-020 LOCKED: combinational pass-through -- m_data/m_valid/m_last = source g's slice/s_valid[g]/s_last[g]; s_ready[g]=m_ready; all other s_ready=0.
REQ-021 Beat transfers when m_valid && m_ready; grant is frame-locked and changes only after a transfer with m_last=1.
REQ-022 Transfer with m_last=1: return to IDLE next cycle; minimum one idle cycle between frames.
REQ-023 s_valid[g] deasserting mid-frame holds the grant; no timeout.
REQ-024 m_src = g in LOCKED, 0 in IDLE; registered at grant.
REQ-025 Per-source channel bit chan[i], reset 0, toggles when a frame from source i completes; m_channel = chan[g].
REQ-026 Any source with s_valid held is granted within NUM_SRC-1 completed frames of other sources (no starvation).
REQ-027 Simultaneous requests in IDLE resolve strictly by REQ-019; no other priority.

Reset
REQ-028 reset forces, next edge: state IDLE, ptr 0, g 0, chan all 0, beat counter 0, len_err all 0; all outputs low.
REQ-029 reset mid-frame abandons the frame: no m_last emitted, chan not toggled, ptr not advanced.

Configuration
REQ-030 Macro FFT_FRAME_ARB_LEN_CHECK_EN.
- Defined: beat counter (width N_FFT_MIN+NUM_SRC-1) clears at grant, increments per transfer; len_err[g] sets if m_last transfers at count != 2^(N_FFT_MIN+g)-1, or count reaches 2^(N_FFT_MIN+g)-1 with m_last=0; sticky until reset; arbitration unaffected.
- Undefined: no counter; len_err tied to 0.

Verification
REQ-031 After reset, all four s_valid high, m_ready=1 -> frames granted in order m_src 0,1,2,3,0; lengths 512,1024,2048,4096,512 beats.
REQ-032 Source 2 alone sends two frames -> m_channel 0 then 1; m_src=2 both times; one idle cycle between.
REQ-033 m_ready toggled 1/0 each cycle during source 1 frame -> every 1024 beats delivered in order; s_ready[1]==m_ready; other s_ready=0.
REQ-034 Source 0 drops s_valid for 10 beats mid-frame while source 3 requests -> grant stays 0 until source 0 m_last.
REQ-035 Reset asserted at beat 100 of source 1 frame -> next cycle state IDLE, all s_ready=0, chan[1]=0, next grant from source 0.
REQ-036 With FFT_FRAME_ARB_LEN_CHECK_EN, source 0 asserts s_last at beat 511 (index 510) -> len_err=4'b0001, held until reset; without macro len_err stays 0.

Source files
------------

// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter
//   Merges NUM_SRC FFT output streams into one stream. Whole frames are
//   interleaved: a source holds the output from its first beat until its
//   m_last beat transfers. Grants go round-robin. Each source has a
//   left/right channel bit that flips after every frame the source completes.
//
// Optional feature: define FFT_FRAME_ARB_LEN_CHECK_EN to enable frame-length
//   checking. Source i must send exactly 2^(N_FFT_MIN+i) beats per frame;
//   otherwise len_err[i] is set and stays set until reset. When the macro is
//   undefined, len_err is tied low.
//
// Ports
//   clk, reset   clock; reset is synchronous and active-high
//   s_data       per-source beats, source i in slice i (2*DATA_WIDTH each)
//   s_valid      per-source valid
//   s_last       per-source end of frame
//   s_ready      per-source ready; only the granted source sees m_ready
//   m_data       merged beat
//   m_valid      merged valid
//   m_last       merged end of frame
//   m_ready      downstream ready
//   m_src        index of the source that owns the current frame
//   m_channel    channel tag of the current frame (0 left, 1 right)
//   len_err      sticky per-source frame-length error flags
module fft_frame_arbiter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned N_FFT_MIN  = 9,
    localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC*2*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SRC-1:0]              s_valid,
    input  logic [NUM_SRC-1:0]              s_last,
    output logic [NUM_SRC-1:0]              s_ready,
    output logic [2*DATA_WIDTH-1:0]         m_data,
    output logic                            m_valid,
    output logic                            m_last,
    input  logic                            m_ready,
    output logic [SRC_W-1:0]                m_src,
    output logic                            m_channel,
    output logic [NUM_SRC-1:0]              len_err
);

    localparam int unsigned BW = 2 * DATA_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state_q;
    logic [SRC_W-1:0]     ptr_q;
    logic [SRC_W-1:0]     ptr_d;
    logic [SRC_W-1:0]     g_q;
    logic [SRC_W-1:0]     m_src_q;
    logic                 m_chan_q;
    logic [NUM_SRC-1:0]   chan_q;
    logic [SRC_W-1:0]     pick;
    logic                 pick_vld;
    logic                 locked;
    logic                 xfer;
    logic [BW-1:0]        src_beat [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
        assign src_beat[i] = s_data[i*BW +: BW];
    end

    assign locked = (state_q == LOCKED);

    // Round-robin pick: scan upward from ptr_q, wrapping at NUM_SRC.
    // The first source with s_valid set wins.
    always_comb begin : rr_pick
        logic [SRC_W:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = {1'b0, ptr_q} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(NUM_SRC)) begin
                idx = idx - (SRC_W+1)'(NUM_SRC);
            end
            if (!pick_vld && s_valid[idx[SRC_W-1:0]]) begin
                pick     = idx[SRC_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        if (g_q == SRC_W'(NUM_SRC - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = g_q + SRC_W'(1);
        end
    end

    // Pass-through from the granted source while LOCKED; everything low in IDLE.
    always_comb begin
        m_data  = '0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        s_ready = '0;
        if (locked) begin
            m_data      = src_beat[g_q];
            m_valid     = s_valid[g_q];
            m_last      = s_last[g_q];
            s_ready[g_q] = m_ready;
        end
    end

    assign xfer      = m_valid && m_ready;
    assign m_src     = m_src_q;
    assign m_channel = m_chan_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            g_q      <= '0;
            chan_q   <= '0;
            m_src_q  <= '0;
            m_chan_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q  <= LOCKED;
                        g_q      <= pick;
                        m_src_q  <= pick;
                        m_chan_q <= chan_q[pick];
                    end
                end
                LOCKED: begin
                    if (xfer && m_last) begin
                        state_q     <= IDLE;
                        ptr_q       <= ptr_d;
                        chan_q[g_q] <= ~chan_q[g_q];
                        m_src_q     <= '0;
                        m_chan_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FFT_FRAME_ARB_LEN_CHECK_EN
    localparam int unsigned CNT_W = N_FFT_MIN + NUM_SRC - 1;

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_lim;
    logic [NUM_SRC-1:0] len_err_q;

    // The index of the last beat, 2^(N_FFT_MIN+g)-1, is built as the
    // inverse of a shifted all-ones mask. For the longest source the whole
    // mask shifts out, so the index becomes all ones.
    assign cnt_lim = ~({CNT_W{1'b1}} << (N_FFT_MIN + 32'(g_q)));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            len_err_q <= '0;
        end else if (!locked && pick_vld) begin
            cnt_q <= '0;
        end else if (xfer) begin
            if (m_last ? (cnt_q != cnt_lim) : (cnt_q == cnt_lim)) begin
                len_err_q[g_q] <= 1'b1;
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = '0;
`endif

endmodule
